// File: rtl/dac_oddr_tx_if.sv
// Parallel sample-word handshake between the DSP output stage and the
// DAC transmit block. The master drives words; the slave returns ready.
interface dac_oddr_tx_if #(
    parameter int PARALLEL_PATH_NUM = 2,
    parameter int ADC_DATA_WIDTH    = 8
);
    logic [PARALLEL_PATH_NUM*ADC_DATA_WIDTH-1:0] s_data;
    logic                                        s_valid;
    logic                                        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_oddr_tx.sv
// DAC transmit word splitter: buffers parallel sample words in a small FIFO
// and emits them as rise/fall sample pairs for the pin-level ODDR primitives.
// Supports training-pattern insertion and sticky, saturating underflow status.
module dac_oddr_tx #(
    parameter int                          PARALLEL_PATH_NUM = 2,
    parameter int                          ADC_DATA_WIDTH    = 8,
    parameter int                          FIFO_DEPTH        = 4,
    parameter logic [ADC_DATA_WIDTH-1:0]   IDLE_CODE         = 8'h80,
    parameter logic [ADC_DATA_WIDTH-1:0]   TRAIN_PATTERN     = 8'hA5
) (
    input  logic                               dac_clk_bufr,
    input  logic                               rst_dac_n,
    dac_oddr_tx_if.slave                       sample_bus,
    input  logic                               tx_en,
    input  logic                               train_en,
    input  logic                               clr_status,
    output logic [ADC_DATA_WIDTH-1:0]          dac_d_rise,
    output logic [ADC_DATA_WIDTH-1:0]          dac_d_fall,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic                               underflow,
    output logic [15:0]                        underflow_cnt
);
    localparam int W       = ADC_DATA_WIDTH;
    localparam int WORD_W  = PARALLEL_PATH_NUM * W;
    localparam int PH_LAST = PARALLEL_PATH_NUM / 2 - 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [WORD_W-1:0] cur_word;
    logic              ph;
    logic              boundary;
    logic              empty;
    logic              push;
    logic              pop;
    logic              uf_evt;

    // Extract sample lane idx (lane 0 is the earliest sample) from a word.
    function automatic logic [W-1:0] lane(input logic [WORD_W-1:0] word, input int idx);
        return word[idx*W +: W];
    endfunction

    // Mode decisions are only taken at a word boundary so a word is never split.
    assign boundary          = (ph == 1'b0);
    assign empty             = (level == '0);
    assign sample_bus.s_ready = (level < LVL_W'(FIFO_DEPTH));
    assign push              = sample_bus.s_valid && sample_bus.s_ready;
    assign pop               = boundary && !train_en && tx_en && !empty;
    assign uf_evt            = boundary && !train_en && tx_en && empty;
    assign fifo_level        = level;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge dac_clk_bufr) begin
        if (push) begin
            mem[wr_ptr] <= sample_bus.s_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge dac_clk_bufr or negedge rst_dac_n) begin
        if (!rst_dac_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Lane sequencing and registered ODDR sample outputs.
    always_ff @(posedge dac_clk_bufr or negedge rst_dac_n) begin
        if (!rst_dac_n) begin
            ph         <= 1'b0;
            cur_word   <= '0;
            dac_d_rise <= IDLE_CODE;
            dac_d_fall <= IDLE_CODE;
        end else if (!boundary) begin
            // Second lane pair of a four-lane word comes from the latched copy.
            dac_d_rise <= lane(cur_word, 2);
            dac_d_fall <= lane(cur_word, 3);
            ph         <= 1'b0;
        end else if (train_en) begin
            dac_d_rise <= TRAIN_PATTERN;
            dac_d_fall <= ~TRAIN_PATTERN;
        end else if (pop) begin
            cur_word   <= mem[rd_ptr];
            dac_d_rise <= lane(mem[rd_ptr], 0);
            dac_d_fall <= lane(mem[rd_ptr], 1);
            ph         <= (PH_LAST > 0);
        end else begin
            // Idle and underflow both park the DAC at midscale.
            dac_d_rise <= IDLE_CODE;
            dac_d_fall <= IDLE_CODE;
        end
    end

    // Sticky underflow flag and saturating counter; a same-edge underflow wins over clear.
    always_ff @(posedge dac_clk_bufr or negedge rst_dac_n) begin
        if (!rst_dac_n) begin
            underflow     <= 1'b0;
            underflow_cnt <= 16'd0;
        end else if (clr_status) begin
            underflow     <= uf_evt;
            underflow_cnt <= uf_evt ? 16'd1 : 16'd0;
        end else if (uf_evt) begin
            underflow <= 1'b1;
            if (underflow_cnt != 16'hFFFF) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_dac_oddr_tx.sv
// Scoreboarded bench for dac_oddr_tx: one two-lane and one four-lane instance.
module tb_dac_oddr_tx;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dac_oddr_tx_if #(.PARALLEL_PATH_NUM(2), .ADC_DATA_WIDTH(8)) bus2 ();
    dac_oddr_tx_if #(.PARALLEL_PATH_NUM(4), .ADC_DATA_WIDTH(8)) bus4 ();

    logic       tx2, tr2, clr2, tx4, tr4, clr4;
    logic [7:0] r2, f2, r4, f4;
    logic [2:0] lv2, lv4;
    logic       uf2, uf4;
    logic [15:0] uc2, uc4;

    dac_oddr_tx #(.PARALLEL_PATH_NUM(2)) u2 (
        .dac_clk_bufr(clk), .rst_dac_n(rst_n), .sample_bus(bus2),
        .tx_en(tx2), .train_en(tr2), .clr_status(clr2),
        .dac_d_rise(r2), .dac_d_fall(f2), .fifo_level(lv2),
        .underflow(uf2), .underflow_cnt(uc2)
    );

    dac_oddr_tx #(.PARALLEL_PATH_NUM(4)) u4 (
        .dac_clk_bufr(clk), .rst_dac_n(rst_n), .sample_bus(bus4),
        .tx_en(tx4), .train_en(tr4), .clr_status(clr4),
        .dac_d_rise(r4), .dac_d_fall(f4), .fifo_level(lv4),
        .underflow(uf4), .underflow_cnt(uc4)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] q2[$];
    logic [15:0] q4[$];
    logic [31:0] w4 [5] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                            32'h100F0E0D, 32'h14131211};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Data-pair monitors: any non-idle, non-training pair must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && !$isunknown({r2, f2}) &&
            {r2, f2} != 16'h8080 && {r2, f2} != 16'hA55A) begin
            if (q2.size() == 0) chk("u2_unexpected_pair", {16'h0, r2, f2}, 32'h8080);
            else chk("u2_sb_pair", {16'h0, r2, f2}, {16'h0, q2.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && !$isunknown({r4, f4}) &&
            {r4, f4} != 16'h8080 && {r4, f4} != 16'hA55A) begin
            if (q4.size() == 0) chk("u4_unexpected_pair", {16'h0, r4, f4}, 32'h8080);
            else chk("u4_sb_pair", {16'h0, r4, f4}, {16'h0, q4.pop_front()});
        end
    end

    initial begin
        rst_n = 1'b1;
        tx2 = 0; tr2 = 0; clr2 = 0; tx4 = 0; tr4 = 0; clr4 = 0;
        bus2.s_data = '0; bus2.s_valid = 0;
        bus4.s_data = '0; bus4.s_valid = 0;
        #1 rst_n = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_u2_out", {r2, f2}, 16'h8080);
        chk("rst_u2_ready", bus2.s_ready, 1);
        chk("rst_u2_level", lv2, 0);
        chk("rst_u2_ucnt", {uf2, uc2}, 0);
        chk("rst_u4_out", {r4, f4}, 16'h8080);
        chk("rst_u4_level", lv4, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_u2_out", {r2, f2}, 16'h8080);

        // Two-lane streaming
        bus2.s_data = {8'h22, 8'h11}; bus2.s_valid = 1;
        tick();
        chk("s2_N_level", lv2, 1);
        chk("s2_N_out", {r2, f2}, 16'h8080);
        bus2.s_data = {8'h44, 8'h33}; tx2 = 1;
        q2.push_back(16'h1122); q2.push_back(16'h3344);
        tick();
        chk("s2_N1_out", {r2, f2}, 16'h1122);
        chk("s2_N1_level", lv2, 1);
        bus2.s_valid = 0;
        tick();
        chk("s2_N2_out", {r2, f2}, 16'h3344);
        chk("s2_N2_level", lv2, 0);
        tick();
        chk("s2_N3_out", {r2, f2}, 16'h8080);
        chk("s2_N3_uf", uf2, 1);
        chk("s2_N3_ucnt", uc2, 1);
        tx2 = 0;
        tick();
        chk("s2_idle_ucnt", uc2, 1);

        // Four-lane fill and back-pressure
        for (int i = 0; i < 4; i++) begin
            bus4.s_data = w4[i]; bus4.s_valid = 1;
            tick();
            chk("p4_fill_level", lv4, i + 1);
        end
        chk("p4_full_ready", bus4.s_ready, 0);
        bus4.s_data = w4[4];
        tick();
        chk("p4_blocked_level", lv4, 4);
        chk("p4_idle_out", {r4, f4}, 16'h8080);
        q4.push_back(16'h0102); q4.push_back(16'h0304);
        q4.push_back(16'h0506); q4.push_back(16'h0708);
        tx4 = 1;
        tick();
        chk("p4_A_out", {r4, f4}, 16'h0102);
        chk("p4_A_ready", bus4.s_ready, 1);
        chk("p4_A_level", lv4, 3);
        tick();
        chk("p4_B_out", {r4, f4}, 16'h0304);
        chk("p4_B_level", lv4, 4);
        bus4.s_valid = 0;
        tick();
        chk("p4_C_out", {r4, f4}, 16'h0506);

        // Training requested mid-word
        tr4 = 1;
        tick();
        chk("tr_D_out", {r4, f4}, 16'h0708);
        chk("tr_D_level", lv4, 3);
        tick();
        chk("tr_E_out", {r4, f4}, 16'hA55A);
        chk("tr_E_level", lv4, 3);
        tick();
        chk("tr_F_out", {r4, f4}, 16'hA55A);
        tr4 = 0; tx4 = 0;
        tick();
        chk("tr_G_out", {r4, f4}, 16'h8080);
        chk("tr_G_level", lv4, 3);
        chk("tr_G_ucnt", uc4, 0);

        // Asynchronous reset with three words queued
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_level", lv4, 0);
        chk("mid_rst_out", {r4, f4}, 16'h8080);
        chk("mid_rst_ready", bus4.s_ready, 1);
        tick();
        rst_n = 1'b1; tx4 = 1;
        repeat (4) tick();
        chk("post_mid_rst_level", lv4, 0);
        chk("post_mid_rst_out", {r4, f4}, 16'h8080);
        chk("post_mid_rst_ucnt", uc4, 4);
        tx4 = 0;

        // Underflow saturation and clear
        tx2 = 1;
        repeat (70000) tick();
        chk("sat_ucnt", uc2, 16'hFFFF);
        chk("sat_uf", uf2, 1);
        clr2 = 1;
        tick();
        chk("clr_uf_ucnt", uc2, 1);
        chk("clr_uf_flag", uf2, 1);
        tx2 = 0;
        tick();
        clr2 = 0;
        chk("clr_idle_ucnt", uc2, 0);
        chk("clr_idle_flag", uf2, 0);

        tick();
        chk("q2_drained", 32'(q2.size()), 0);
        chk("q4_drained", 32'(q4.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
